ir_beacon_tx: RTL and testbench

IR beacon transmitter. It is the other end of the IR frequency-decision receiver: it drives an IR LED with a square wave whose frequency is chosen by a 3-bit code, the same code space the receiver reports as its final answer. Each burst sends a programmed number of pulses, or runs continuously until stopped. It sits between the control logic / test switches and the IR emitter pin.

---
 rtl/ir_beacon_tx.sv | 137 +++++++++++++
 tb/tb_ir_beacon_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: drives an IR LED with a square wave. The frequency
// comes from a 3-bit code, and each burst sends a programmed number of
// pulses, or runs continuously when num_pulses is 0. Every output is
// registered.
module ir_beacon_tx #(
  parameter int BASE_HALF = 50000,  // half-period in cycles for code 1
  parameter int CNT_W     = 24      // must hold BASE_HALF << 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  freq_code,
  input  logic [7:0]  num_pulses,
  input  logic        stop,
  output logic        ir_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] pulse_count,
  output logic [2:0]  code_latched
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_num;
  logic [2:0]       r_code;
  logic [15:0]      r_pc;
  logic             r_ir;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic [CNT_W-1:0] w_base;
  logic [2:0]       w_shift;
  logic [CNT_W-1:0] w_half;
  logic             w_last;
  logic [15:0]      w_pc_inc;
  logic             w_burst_end;
  logic             w_accept;

  // Half-period for the latched code, and the end-of-phase / end-of-burst decisions.
  // r_code is only used while busy, when it is never 0, so the shift stays in 0..6.
  assign w_base      = CNT_W'(BASE_HALF);
  assign w_shift     = r_code - 3'd1;
  assign w_half      = w_base << w_shift;
  assign w_last      = (r_cnt == (w_half - CNT_W'(1)));
  assign w_pc_inc    = r_pc + 16'd1;
  assign w_burst_end = (r_num != 8'd0) && (w_pc_inc == {8'd0, r_num});
  assign w_accept    = start && (freq_code != 3'd0) && !stop;

  // Burst FSM: IDLE waits for a valid start; HIGH/LOW each last H cycles.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make update order matter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_num     <= '0;
      r_code    <= '0;
      r_pc      <= '0;
      r_ir      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_code  <= freq_code;
            r_num   <= num_pulses;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_ir    <= 1'b1;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (stop) begin
            r_ir      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_last) begin
            r_cnt   <= '0;
            r_ir    <= 1'b0;
            r_state <= ST_LOW;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOW: begin
          // stop wins over completion: the partial/final pulse is not counted.
          if (stop) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_last) begin
            r_pc  <= w_pc_inc;
            r_cnt <= '0;
            if (w_burst_end) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ir    <= 1'b1;
              r_state <= ST_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_ir    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ir_out       = r_ir;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign pulse_count  = r_pc;
  assign code_latched = r_code;

endmodule

// File: tb/tb_ir_beacon_tx.sv
// Self-checking bench for ir_beacon_tx with BASE_HALF=4. A scoreboard queue
// holds the expected outcome of each burst, pushed when the burst is started
// and popped when done is observed.
module tb_ir_beacon_tx;

  localparam int BH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  freq_code;
  logic [7:0]  num_pulses;
  logic        stop;
  logic        ir_out;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] pulse_count;
  logic [2:0]  code_latched;

  typedef struct {
    logic        ab;
    logic [15:0] pc;
    logic [2:0]  code;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ir_beacon_tx #(.BASE_HALF(BH), .CNT_W(24)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .freq_code    (freq_code),
    .num_pulses   (num_pulses),
    .stop         (stop),
    .ir_out       (ir_out),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .pulse_count  (pulse_count),
    .code_latched (code_latched)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every done pulse must match the oldest queued burst.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done=1 with pc=%0d, required no done", pulse_count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (aborted !== e.ab || pulse_count !== e.pc || code_latched !== e.code) begin
          errors++;
          $display("FAIL sb_done: got aborted=%b pc=%0d code=%0d, required aborted=%b pc=%0d code=%0d",
                   aborted, pulse_count, code_latched, e.ab, e.pc, e.code);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive_start(input logic [2:0] code, input logic [7:0] n);
    start      = 1'b1;
    freq_code  = code;
    num_pulses = n;
  endtask

  task automatic push_exp(input logic ab, input logic [15:0] pc, input logic [2:0] code);
    exp_t e;
    e.ab = ab; e.pc = pc; e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; freq_code = '0; num_pulses = '0; stop = 1'b0;
    repeat (3) step();
    checks++;
    if ({ir_out, busy, done, aborted, pulse_count, code_latched} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got ir=%b busy=%b done=%b ab=%b pc=%0d code=%0d, required all 0",
               ir_out, busy, done, aborted, pulse_count, code_latched);
    end
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_burst();
    drive_start(3'd1, 8'd3);
    push_exp(1'b0, 16'd3, 3'd1);
    for (int k = 0; k < 24; k++) begin
      step();
      start = 1'b0;
      checks++;
      if (ir_out !== (((k / BH) % 2) == 0) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL burst_wave[%0d]: got ir=%b busy=%b done=%b, required ir=%b busy=1 done=0",
                 k, ir_out, busy, done, ((k / BH) % 2) == 0);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ir_out !== 1'b0 || pulse_count !== 16'd3) begin
      errors++;
      $display("FAIL burst_end: got done=%b busy=%b ir=%b pc=%0d, required done=1 busy=0 ir=0 pc=3",
               done, busy, ir_out, pulse_count);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL burst_done_width: got done=%b, required 0", done);
    end
  endtask

  task automatic test_continuous();
    drive_start(3'd3, 8'd0);
    for (int k = 0; k < 100; k++) begin
      step();
      start = 1'b0;
      checks++;
      if (ir_out !== (((k / 16) % 2) == 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL cont_wave[%0d]: got ir=%b done=%b, required ir=%b done=0",
                 k, ir_out, done, ((k / 16) % 2) == 0);
      end
    end
    stop = 1'b1;
    push_exp(1'b1, 16'd3, 3'd3);
    step();
    stop = 1'b0;
    checks++;
    if (ir_out !== 1'b0 || done !== 1'b1 || aborted !== 1'b1 || busy !== 1'b0 || pulse_count !== 16'd3) begin
      errors++;
      $display("FAIL cont_stop: got ir=%b done=%b ab=%b busy=%b pc=%0d, required 0 1 1 0 3",
               ir_out, done, aborted, busy, pulse_count);
    end
    step();
  endtask

  task automatic test_invalid_code();
    drive_start(3'd0, 8'd2);
    step();
    start = 1'b0;
    // start together with stop in IDLE is ignored too
    drive_start(3'd1, 8'd1);
    stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || ir_out !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL invalid_ignored[%0d]: got busy=%b ir=%b done=%b, required 0 0 0",
                 k, busy, ir_out, done);
      end
    end
    drive_start(3'd2, 8'd1);
    push_exp(1'b0, 16'd1, 3'd2);
    for (int k = 0; k < 16; k++) begin
      step();
      start = 1'b0;
      checks++;
      if (ir_out !== (k < 8)) begin
        errors++;
        $display("FAIL code2_wave[%0d]: got ir=%b, required %b", k, ir_out, k < 8);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || code_latched !== 3'd2) begin
      errors++;
      $display("FAIL code2_end: got done=%b code=%0d, required done=1 code=2", done, code_latched);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive_start(3'd1, 8'd2);
    push_exp(1'b0, 16'd2, 3'd1);
    for (int k = 0; k < 16; k++) begin
      step();
      start = 1'b0;
      if (k == 3) drive_start(3'd7, 8'd9);
      checks++;
      if (ir_out !== (((k / BH) % 2) == 0) || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_ignore_wave[%0d]: got ir=%b busy=%b, required ir=%b busy=1",
                 k, ir_out, busy, ((k / BH) % 2) == 0);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || pulse_count !== 16'd2 || code_latched !== 3'd1) begin
      errors++;
      $display("FAIL busy_ignore_end: got done=%b pc=%0d code=%0d, required 1 2 1",
               done, pulse_count, code_latched);
    end
    drive_start(3'd1, 8'd1);
    push_exp(1'b0, 16'd1, 3'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      checks++;
      if (ir_out !== (k < BH) || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wave[%0d]: got ir=%b busy=%b, required ir=%b busy=1", k, ir_out, busy, k < BH);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || pulse_count !== 16'd1) begin
      errors++;
      $display("FAIL b2b_end: got done=%b pc=%0d, required done=1 pc=1", done, pulse_count);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive_start(3'd1, 8'd5);
    step();
    start = 1'b0;
    step();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (ir_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got ir=%b busy=%b, required 0 0", ir_out, busy);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (ir_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle[%0d]: got ir=%b busy=%b done=%b, required 0 0 0",
                 k, ir_out, busy, done);
      end
    end
  endtask

  task automatic test_collision();
    drive_start(3'd1, 8'd2);
    for (int k = 0; k < 16; k++) begin
      step();
      start = 1'b0;
    end
    stop = 1'b1;
    push_exp(1'b1, 16'd1, 3'd1);
    step();
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || pulse_count !== 16'd1) begin
      errors++;
      $display("FAIL collision: got done=%b ab=%b pc=%0d, required 1 1 1", done, aborted, pulse_count);
    end
    step();
    checks++;
    if (aborted !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL collision_after: got done=%b ab=%b, required 0 0", done, aborted);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_continuous();
    test_invalid_code();
    test_back_to_back();
    test_reset_mid();
    test_collision();
    repeat (4) step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending bursts, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
